// File: rtl/int_issue_queue_if.sv
// -----------------------------------------------------------------------------
// int_issue_queue_if
// Groups the dispatch, common-data-bus and issue handshake signals of the
// integer issue queue.
//   dispatch_*            : instruction write from the dispatch unit
//   CDB_*                 : result broadcast used to wake waiting operands
//   issueque_full_integer : back-pressure to dispatch
//   issue_*               : instruction handed to the integer execution unit
// Modports: master = dispatch/CDB/execution-unit side, slave = the queue.
// -----------------------------------------------------------------------------
interface int_issue_queue_if #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 6
);
   logic                  dispatch_en_integer;
   logic [3:0]            dispatch_opcode;
   logic [TAG_WIDTH-1:0]  dispatch_rd_tag;
   logic [TAG_WIDTH-1:0]  dispatch_rs1_tag;
   logic [TAG_WIDTH-1:0]  dispatch_rs2_tag;
   logic [DATA_WIDTH-1:0] dispatch_rs1_data;
   logic [DATA_WIDTH-1:0] dispatch_rs2_data;
   logic                  dispatch_rs1_valid;
   logic                  dispatch_rs2_valid;
   logic [TAG_WIDTH-1:0]  CDB_tag;
   logic                  CDB_valid;
   logic [DATA_WIDTH-1:0] CDB_data;
   logic                  issueque_full_integer;
   logic                  issue_ready;
   logic                  issue_valid;
   logic [3:0]            issue_opcode;
   logic [TAG_WIDTH-1:0]  issue_rd_tag;
   logic [DATA_WIDTH-1:0] issue_rs1_data;
   logic [DATA_WIDTH-1:0] issue_rs2_data;

   modport master (
      output dispatch_en_integer, dispatch_opcode, dispatch_rd_tag,
             dispatch_rs1_tag, dispatch_rs2_tag, dispatch_rs1_data,
             dispatch_rs2_data, dispatch_rs1_valid, dispatch_rs2_valid,
             CDB_tag, CDB_valid, CDB_data, issue_ready,
      input  issueque_full_integer, issue_valid, issue_opcode,
             issue_rd_tag, issue_rs1_data, issue_rs2_data
   );

   modport slave (
      input  dispatch_en_integer, dispatch_opcode, dispatch_rd_tag,
             dispatch_rs1_tag, dispatch_rs2_tag, dispatch_rs1_data,
             dispatch_rs2_data, dispatch_rs1_valid, dispatch_rs2_valid,
             CDB_tag, CDB_valid, CDB_data, issue_ready,
      output issueque_full_integer, issue_valid, issue_opcode,
             issue_rd_tag, issue_rs1_data, issue_rs2_data
   );
endinterface

// File: rtl/int_issue_queue.sv
// -----------------------------------------------------------------------------
// int_issue_queue
// Age-ordered integer issue queue (index 0 oldest, compacted on removal).
// Entries wait for their operands on the CDB; the oldest entry with both
// operands ready moves into a registered output stage whenever that stage is
// free (issue_valid=0 or issue_ready=1).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   iq    : int_issue_queue_if.slave (dispatch, CDB, full, issue handshake)
// Build option:
//   IQ_CDB_WAKEUP_FORWARD_EN - when defined, an operand matched by the CDB in
//   the current cycle already counts as ready for selection and its data goes
//   straight into the output stage, saving one cycle of wakeup latency.
// -----------------------------------------------------------------------------
module int_issue_queue #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 6,
   parameter int DEPTH      = 4
) (
   input  logic             clk,
   input  logic             reset,
   int_issue_queue_if.slave iq
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   typedef struct packed {
      logic                  busy;
      logic [3:0]            opcode;
      logic [TAG_WIDTH-1:0]  rd_tag;
      logic [TAG_WIDTH-1:0]  rs1_tag;
      logic [DATA_WIDTH-1:0] rs1_data;
      logic                  rs1_rdy;
      logic [TAG_WIDTH-1:0]  rs2_tag;
      logic [DATA_WIDTH-1:0] rs2_data;
      logic                  rs2_rdy;
   } entry_t;

   entry_t                q_r     [DEPTH];
   entry_t                wk_s    [DEPTH];
   entry_t                shift_s [DEPTH];
   entry_t                q_nxt_s [DEPTH];
   entry_t                new_s;
   entry_t                sel_s;
   logic [DEPTH-1:0]      elig_s;
   logic [IW-1:0]         sel_idx_s;
   logic                  sel_found_s;
   logic                  stage_free_s;
   logic                  remove_s;
   logic                  accept_s;
   logic [CW-1:0]         count_r;
   logic [CW-1:0]         cnt_after_s;
   logic [CW-1:0]         count_nxt_s;
   logic                  full_r;
   logic                  valid_r;
   logic [3:0]            opcode_r;
   logic [TAG_WIDTH-1:0]  rd_tag_r;
   logic [DATA_WIDTH-1:0] rs1_data_r;
   logic [DATA_WIDTH-1:0] rs2_data_r;

   // True when a broadcast supplies a still-waiting operand of a live entry.
   function automatic logic cdb_hit(input logic                 busy,
                                    input logic                 rdy,
                                    input logic [TAG_WIDTH-1:0] tag,
                                    input logic                 cdb_valid,
                                    input logic [TAG_WIDTH-1:0] cdb_tag);
      return cdb_valid & busy & ~rdy & (tag == cdb_tag);
   endfunction

   // Stored entries as they look after this cycle's CDB broadcast.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         wk_s[i] = q_r[i];
         wk_s[i].rs1_rdy  = q_r[i].rs1_rdy |
                            cdb_hit(q_r[i].busy, q_r[i].rs1_rdy, q_r[i].rs1_tag, iq.CDB_valid, iq.CDB_tag);
         wk_s[i].rs1_data = cdb_hit(q_r[i].busy, q_r[i].rs1_rdy, q_r[i].rs1_tag, iq.CDB_valid, iq.CDB_tag) ?
                            iq.CDB_data : q_r[i].rs1_data;
         wk_s[i].rs2_rdy  = q_r[i].rs2_rdy |
                            cdb_hit(q_r[i].busy, q_r[i].rs2_rdy, q_r[i].rs2_tag, iq.CDB_valid, iq.CDB_tag);
         wk_s[i].rs2_data = cdb_hit(q_r[i].busy, q_r[i].rs2_rdy, q_r[i].rs2_tag, iq.CDB_valid, iq.CDB_tag) ?
                            iq.CDB_data : q_r[i].rs2_data;
      end
   end

   // Oldest-ready selection; scanning downward leaves the lowest index.
   always_comb begin
      elig_s      = '0;
      sel_found_s = 1'b0;
      sel_idx_s   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
`ifdef IQ_CDB_WAKEUP_FORWARD_EN
         elig_s[i] = wk_s[i].busy & wk_s[i].rs1_rdy & wk_s[i].rs2_rdy;
`else
         elig_s[i] = q_r[i].busy & q_r[i].rs1_rdy & q_r[i].rs2_rdy;
`endif
         sel_found_s = sel_found_s | elig_s[i];
         sel_idx_s   = elig_s[i] ? IW'(i) : sel_idx_s;
      end
      // Woken data is used so a forwarded operand carries the CDB value.
      sel_s        = wk_s[sel_idx_s];
      stage_free_s = ~valid_r | iq.issue_ready;
      remove_s     = stage_free_s & sel_found_s;
   end

   // Compaction after removal, then dispatch into the first free slot.
   always_comb begin
      for (int i = 0; i < DEPTH - 1; i++) begin
         shift_s[i] = (remove_s && (i >= int'(sel_idx_s))) ? wk_s[i+1] : wk_s[i];
      end
      shift_s[DEPTH-1] = remove_s ? '0 : wk_s[DEPTH-1];

      // Full is judged on the registered flag, so a slot freed by this
      // edge's issue is only offered to dispatch on the following edge.
      accept_s    = iq.dispatch_en_integer & ~full_r;
      cnt_after_s = count_r - CW'(remove_s);
      count_nxt_s = cnt_after_s + CW'(accept_s);

      // The incoming instruction sees the same broadcast as stored entries.
      new_s          = '0;
      new_s.busy     = 1'b1;
      new_s.opcode   = iq.dispatch_opcode;
      new_s.rd_tag   = iq.dispatch_rd_tag;
      new_s.rs1_tag  = iq.dispatch_rs1_tag;
      new_s.rs1_rdy  = iq.dispatch_rs1_valid |
                       cdb_hit(1'b1, iq.dispatch_rs1_valid, iq.dispatch_rs1_tag, iq.CDB_valid, iq.CDB_tag);
      new_s.rs1_data = cdb_hit(1'b1, iq.dispatch_rs1_valid, iq.dispatch_rs1_tag, iq.CDB_valid, iq.CDB_tag) ?
                       iq.CDB_data : iq.dispatch_rs1_data;
      new_s.rs2_tag  = iq.dispatch_rs2_tag;
      new_s.rs2_rdy  = iq.dispatch_rs2_valid |
                       cdb_hit(1'b1, iq.dispatch_rs2_valid, iq.dispatch_rs2_tag, iq.CDB_valid, iq.CDB_tag);
      new_s.rs2_data = cdb_hit(1'b1, iq.dispatch_rs2_valid, iq.dispatch_rs2_tag, iq.CDB_valid, iq.CDB_tag) ?
                       iq.CDB_data : iq.dispatch_rs2_data;

      for (int i = 0; i < DEPTH; i++) begin
         q_nxt_s[i] = (accept_s && (cnt_after_s == CW'(i))) ? new_s : shift_s[i];
      end
   end

   // Queue storage, occupancy count and full flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            q_r[i] <= '0;
         end
         count_r <= '0;
         full_r  <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            q_r[i] <= q_nxt_s[i];
         end
         count_r <= count_nxt_s;
         full_r  <= (count_nxt_s == CW'(DEPTH));
      end
   end

   // Output stage: load on selection, empty when free with nothing ready,
   // otherwise hold while the execution unit stalls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_r    <= 1'b0;
         opcode_r   <= 4'h0;
         rd_tag_r   <= '0;
         rs1_data_r <= '0;
         rs2_data_r <= '0;
      end else if (remove_s) begin
         valid_r    <= 1'b1;
         opcode_r   <= sel_s.opcode;
         rd_tag_r   <= sel_s.rd_tag;
         rs1_data_r <= sel_s.rs1_data;
         rs2_data_r <= sel_s.rs2_data;
      end else if (stage_free_s) begin
         valid_r    <= 1'b0;
      end
   end

   assign iq.issueque_full_integer = full_r;
   assign iq.issue_valid           = valid_r;
   assign iq.issue_opcode          = opcode_r;
   assign iq.issue_rd_tag          = rd_tag_r;
   assign iq.issue_rs1_data        = rs1_data_r;
   assign iq.issue_rs2_data        = rs2_data_r;
endmodule
